// File: rtl/interp_rate_ctrl_pkg.sv
// interp_pkg: shared state type and default constants for the interpolator rate scheduler
package interp_pkg;
   typedef enum logic {IDLE, RUN} state_t;
   localparam int WIN_DEF  = 16;
   localparam int CNTW_DEF = 12;
   localparam int RDEF     = 8;
   localparam int UF_CNT_W = 8;
endpackage

// File: rtl/interp_rate_ctrl_if.sv
// interp_rate_ctrl_if: low-rate sample input and high-rate output stream bundle
//   s_valid/s_data/s_ready : upstream sample handshake (signed s_data)
//   m_valid/m_data/m_first : registered high-rate output, m_first marks phase 0
interface interp_rate_ctrl_if import interp_pkg::*; #(parameter int Win = WIN_DEF);
   logic                  s_valid;
   logic                  s_ready;
   logic signed [Win-1:0] s_data;
   logic                  m_valid;
   logic                  m_first;
   logic signed [Win-1:0] m_data;
   modport master (output s_valid, s_data, input s_ready, m_valid, m_first, m_data);
   modport slave  (input s_valid, s_data, output s_ready, m_valid, m_first, m_data);
endinterface

// File: rtl/interp_rate_ctrl_hold_reg1.sv
// hold_reg1: one-entry valid/ready holding register with external pop
//   i_valid/i_data/o_ready : push handshake; ready while empty or popping
//   i_pop                  : consumer takes the held sample this cycle
//   o_full/o_data          : holding register state
module hold_reg1 import interp_pkg::*; #(parameter int Win = WIN_DEF) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_valid,
   input  logic signed [Win-1:0] i_data,
   input  logic                  i_pop,
   output logic                  o_ready,
   output logic                  o_full,
   output logic signed [Win-1:0] o_data
);
   logic                  r_full;
   logic signed [Win-1:0] r_data;
   assign o_ready = !r_full | i_pop;
   assign o_full  = r_full;
   assign o_data  = r_data;
   always_ff @(posedge clk)
      if (rst) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (i_valid && o_ready) begin
         r_full <= 1'b1;
         r_data <= i_data;
      end else if (i_pop)
         r_full <= 1'b0;
endmodule

// File: rtl/interp_rate_ctrl.sv
// interp_rate_ctrl: zero-stuffing rate scheduler feeding the interpolation filter chain
//   clk, rst         : clock, synchronous active-high reset
//   en               : run enable (frames always complete)
//   cfg_we/cfg_ratio : load shadow ratio (0 saturates to 1), applied in IDLE or at frame wrap
//   uf_clr           : clear underflow flag and counter
//   bus (slave)      : sample handshake in, registered high-rate stream out
//   busy             : state != IDLE
//   underflow/uf_count : sticky flag and saturating count of empty phase-0 cycles
//   ZOH_EN           : when defined, phases 1..R-1 and underflows repeat the last phase-0 sample
module interp_rate_ctrl #(
   parameter int Win  = interp_pkg::WIN_DEF,
   parameter int CNTW = interp_pkg::CNTW_DEF,
   parameter int RDEF = interp_pkg::RDEF
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en,
   input  logic                            cfg_we,
   input  logic [CNTW-1:0]                 cfg_ratio,
   input  logic                            uf_clr,
   interp_rate_ctrl_if.slave               bus,
   output logic                            busy,
   output logic                            underflow,
   output logic [interp_pkg::UF_CNT_W-1:0] uf_count
);
   import interp_pkg::*;
   state_t                r_state, w_state_nxt;
   logic [CNTW-1:0]       r_phase, w_phase_nxt, r_ratio_act, r_ratio_shd, w_ratio_shd_nxt;
   logic                  w_run, w_last, w_full, w_pop, w_uf;
   logic signed [Win-1:0] w_hold, w_fill, w_data_nxt, r_m_data;
   logic                  r_m_valid, r_m_first, r_uf;
   logic [UF_CNT_W-1:0]   r_uf_cnt;

   hold_reg1 #(.Win(Win)) u_hold (
      .clk(clk), .rst(rst), .i_valid(bus.s_valid), .i_data(bus.s_data), .i_pop(w_pop),
      .o_ready(bus.s_ready), .o_full(w_full), .o_data(w_hold)
   );

   assign w_run  = r_state == RUN;
   assign w_last = r_phase == r_ratio_act - 1'b1;
   assign w_pop  = w_run && r_phase == '0 && w_full;
   assign w_uf   = w_run && r_phase == '0 && !w_full;
   // Same-cycle cfg_we must be visible to a wrap happening now, so ratio_act loads this value.
   assign w_ratio_shd_nxt = !cfg_we ? r_ratio_shd : cfg_ratio == '0 ? CNTW'(1) : cfg_ratio;

`ifdef ZOH_EN
   logic signed [Win-1:0] r_last;
   always_ff @(posedge clk)
      if (rst) r_last <= '0;
      else if (w_pop) r_last <= w_hold;
   assign w_fill = r_last;
`else
   assign w_fill = '0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = '0;
      w_data_nxt  = '0;
      if (w_run) begin
         w_phase_nxt = w_last ? '0 : r_phase + 1'b1;
         w_data_nxt  = w_pop ? w_hold : w_fill;
         w_state_nxt = (w_last && !en) ? IDLE : RUN;
      end else
         w_state_nxt = (en && w_full) ? RUN : IDLE;
   end

   always_ff @(posedge clk)
      if (rst) begin
         r_state <= IDLE;
         r_phase <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_phase <= w_phase_nxt;
      end

   always_ff @(posedge clk)
      if (rst) begin
         r_ratio_act <= CNTW'(RDEF);
         r_ratio_shd <= CNTW'(RDEF);
         r_m_valid   <= 1'b0;
         r_m_data    <= '0;
         r_m_first   <= 1'b0;
      end else begin
         r_ratio_shd <= w_ratio_shd_nxt;
         if (!w_run || w_last) r_ratio_act <= w_ratio_shd_nxt;
         r_m_valid   <= w_run;
         r_m_data    <= w_data_nxt;
         r_m_first   <= w_run && r_phase == '0;
      end

   // A clear coinciding with an event restarts the count at that event.
   always_ff @(posedge clk)
      if (rst) begin
         r_uf     <= 1'b0;
         r_uf_cnt <= '0;
      end else if (uf_clr) begin
         r_uf     <= w_uf;
         r_uf_cnt <= UF_CNT_W'(w_uf);
      end else if (w_uf) begin
         r_uf     <= 1'b1;
         r_uf_cnt <= r_uf_cnt + UF_CNT_W'(r_uf_cnt != '1);
      end

   assign bus.m_valid = r_m_valid;
   assign bus.m_data  = r_m_data;
   assign bus.m_first = r_m_first;
   assign busy        = w_run;
   assign underflow   = r_uf;
   assign uf_count    = r_uf_cnt;
endmodule

// File: tb/tb_interp_rate_ctrl.sv
// tb_interp_rate_ctrl: directed table-driven bench for interp_rate_ctrl
module tb_interp_rate_ctrl;
   import interp_pkg::*;
   logic                clk = 1'b0, rst = 1'b1, en = 1'b0, cfg_we = 1'b0, uf_clr = 1'b0;
   logic [11:0]         cfg_ratio = '0;
   logic                busy, underflow;
   logic [UF_CNT_W-1:0] uf_count;
   int                  n_cmp = 0, n_bad = 0;
   int                  q_d[$];
   logic                q_f[$];
`ifdef ZOH_EN
   localparam bit ZOH = 1'b1;
`else
   localparam bit ZOH = 1'b0;
`endif

   interp_rate_ctrl_if #(.Win(16)) bus();
   interp_rate_ctrl #(.Win(16), .CNTW(12), .RDEF(8)) dut (
      .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ratio(cfg_ratio), .uf_clr(uf_clr),
      .bus(bus), .busy(busy), .underflow(underflow), .uf_count(uf_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] r;
      int          n;
      int          d[10];
      int          ne;
      int          e[12];
      logic [11:0] ef;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.m_valid) begin
         q_d.push_back(int'(bus.m_data));
         q_f.push_back(bus.m_first);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; cfg_we = 1'b0; uf_clr = 1'b0;
      bus.s_valid = 1'b0; bus.s_data = '0;
      tick(); tick();
      rst = 1'b0;
      q_d.delete(); q_f.delete();
   endtask

   task automatic set_ratio(input logic [11:0] r);
      cfg_we = 1'b1; cfg_ratio = r;
      tick();
      cfg_we = 1'b0;
      tick();
   endtask

   task automatic chk_q(input string tag, input int i, input int d, input logic f);
      if (i >= q_d.size()) chk($sformatf("%s[%0d] present", tag, i), 0, 1);
      else begin
         chk($sformatf("%s[%0d] data", tag, i), q_d[i], d);
         chk($sformatf("%s[%0d] first", tag, i), int'(q_f[i]), int'(f));
      end
   endtask

   task automatic wait_idle(input string tag);
      int cyc = 0;
      while ((busy || bus.m_valid) && cyc < 100) begin tick(); cyc++; end
      chk({tag, " idle timeout"}, int'(cyc < 100), 1);
   endtask

   task automatic run_stream(input vec_t v, input int k);
      int idx = 0, cyc = 0;
      bit armed = 0, xfer, rdy_drop = 0;
      string tag = $sformatf("vec%0d", k);
      do_reset();
      set_ratio(v.r);
      en = 1'b1;
      while (cyc < 400 && !(en == 1'b0 && !busy && !bus.m_valid)) begin
         bus.s_valid = idx < v.n;
         bus.s_data  = 16'(v.d[idx < v.n ? idx : 0]);
         if (armed && bus.s_ready) en = 1'b0;
         if (v.r == 12'd1 && busy && !bus.s_ready) rdy_drop = 1;
         xfer = bus.s_valid && bus.s_ready;
         tick();
         cyc++;
         if (xfer) begin
            idx++;
            if (idx == v.n) armed = 1;
         end
      end
      chk({tag, " done"}, int'(cyc < 400), 1);
      chk({tag, " count"}, q_d.size(), v.ne);
      for (int i = 0; i < v.ne; i++) chk_q(tag, i, v.e[i], v.ef[i]);
      chk({tag, " underflow"}, int'(underflow), 0);
      chk({tag, " s_ready drop"}, int'(rdy_drop), 0);
   endtask

   vec_t tbl[$];

   initial begin
      vec_t v;
      int   cyc, k;
      bit   c1, c2, xfer;
      logic [17:0] efm;

      v.r = 12'd4; v.n = 3; v.d = '{100, -200, 300, 0, 0, 0, 0, 0, 0, 0}; v.ne = 12;
`ifdef ZOH_EN
      v.e = '{100, 100, 100, 100, -200, -200, -200, -200, 300, 300, 300, 300};
`else
      v.e = '{100, 0, 0, 0, -200, 0, 0, 0, 300, 0, 0, 0};
`endif
      v.ef = 12'h111; tbl.push_back(v);
      v.r = 12'd1; v.n = 10; v.d = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10}; v.ne = 10;
      v.e = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 0}; v.ef = 12'h3FF; tbl.push_back(v);
`ifdef ZOH_EN
      v.r = 12'd3; v.n = 2; v.d = '{7, -7, 0, 0, 0, 0, 0, 0, 0, 0}; v.ne = 6;
      v.e = '{7, 7, 7, -7, -7, -7, 0, 0, 0, 0, 0, 0}; v.ef = 12'h009; tbl.push_back(v);
`endif

      // reset state, with a sample offered during reset that must be discarded
      rst = 1'b1; bus.s_valid = 1'b1; bus.s_data = 16'sd55;
      tick(); tick();
      rst = 1'b0; bus.s_valid = 1'b0;
      chk("rst m_valid", int'(bus.m_valid), 0);
      chk("rst m_data", int'(bus.m_data), 0);
      chk("rst m_first", int'(bus.m_first), 0);
      chk("rst busy", int'(busy), 0);
      chk("rst underflow", int'(underflow), 0);
      chk("rst uf_count", int'(uf_count), 0);
      chk("rst s_ready", int'(bus.s_ready), 1);
      en = 1'b1;
      tick(); tick(); tick();
      chk("rst pending dropped", int'(busy), 0);

      foreach (tbl[i]) run_stream(tbl[i], i);

      // underflow: second sample withheld, frame 2 is empty
      do_reset();
      set_ratio(12'd4);
      en = 1'b1; bus.s_valid = 1'b1; bus.s_data = 16'sd5;
      tick();
      bus.s_valid = 1'b0;
      cyc = 0;
      while (q_d.size() < 5 && cyc < 50) begin tick(); cyc++; end
      chk("uf reach frame2", int'(cyc < 50), 1);
      en = 1'b0;
      chk("uf flag", int'(underflow), 1);
      chk("uf count", int'(uf_count), 1);
      wait_idle("uf");
      chk("uf outputs", q_d.size(), 8);
      for (int i = 0; i < 8; i++) chk_q("uf", i, i == 0 ? 5 : (ZOH ? 5 : 0), i == 0 || i == 4);
      chk("uf flag held", int'(underflow), 1);
      chk("uf count held", int'(uf_count), 1);
      uf_clr = 1'b1;
      tick();
      uf_clr = 1'b0;
      chk("uf_clr flag", int'(underflow), 0);
      chk("uf_clr count", int'(uf_count), 0);

      // ratio change mid-frame (8 -> 3) and then same-cycle-as-wrap change to 0 (-> 1)
      do_reset();
      en = 1'b1; bus.s_valid = 1'b1; k = 1; c1 = 0; c2 = 0; cyc = 0;
      while (q_d.size() < 18 && cyc < 200) begin
         bus.s_data = 16'(k);
         cfg_we = 1'b0;
         if (q_d.size() == 2 && !c1) begin cfg_we = 1'b1; cfg_ratio = 12'd3; c1 = 1; end
         if (q_d.size() == 13 && !c2) begin cfg_we = 1'b1; cfg_ratio = 12'd0; c2 = 1; end
         xfer = bus.s_ready;
         tick();
         cyc++;
         if (xfer) k++;
      end
      chk("ratio reach", int'(cyc < 200), 1);
      cfg_we = 1'b0; en = 1'b0; bus.s_valid = 1'b0;
      wait_idle("ratio");
      efm = 18'b11_1100_1001_0000_0001;
      for (int i = 0; i < 18; i++)
         if (i < q_f.size()) chk($sformatf("ratio first[%0d]", i), int'(q_f[i]), int'(efm[i]));
         else chk($sformatf("ratio[%0d] present", i), 0, 1);
      if (q_d.size() > 8) begin
         chk("ratio data0", q_d[0], 1);
         chk("ratio data8", q_d[8], 2);
      end else chk("ratio data present", q_d.size(), 18);
      chk("ratio underflow", int'(underflow), 0);

      // en dropped at phase 1 of an R=5 frame: frame completes, then IDLE
      do_reset();
      set_ratio(12'd5);
      en = 1'b1; bus.s_valid = 1'b1; bus.s_data = 16'sd9;
      tick();
      bus.s_valid = 1'b0;
      cyc = 0;
      while (q_d.size() < 1 && cyc < 20) begin tick(); cyc++; end
      en = 1'b0;
      wait_idle("en");
      chk("en outputs", q_d.size(), 5);
      for (int i = 0; i < 5; i++) chk_q("en", i, i == 0 ? 9 : (ZOH ? 9 : 0), i == 0);
      chk("en m_valid", int'(bus.m_valid), 0);
      chk("en busy", int'(busy), 0);

      // reset mid-frame with a second sample held
      do_reset();
      set_ratio(12'd5);
      en = 1'b1; k = 0; cyc = 0;
      while (k < 2 && cyc < 20) begin
         bus.s_valid = 1'b1;
         bus.s_data = k == 0 ? 16'sd11 : 16'sd22;
         xfer = bus.s_ready;
         tick();
         cyc++;
         if (xfer) k++;
      end
      bus.s_valid = 1'b0;
      chk("mid data before rst", int'(bus.m_data), 11);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid rst m_valid", int'(bus.m_valid), 0);
      chk("mid rst m_data", int'(bus.m_data), 0);
      chk("mid rst m_first", int'(bus.m_first), 0);
      chk("mid rst busy", int'(busy), 0);
      chk("mid rst s_ready", int'(bus.s_ready), 1);
      q_d.delete(); q_f.delete();
      for (int i = 0; i < 6; i++) tick();
      chk("mid held dropped busy", int'(busy), 0);
      chk("mid held dropped outputs", q_d.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
